alu_secuencial: RTL and testbench



---
 rtl/alu_secuencial.sv | 204 ++++++++++++++++++++
 tb/tb_alu_secuencial.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_secuencial.sv
// alu_secuencial -- registered, parametrised ALU with a start/listo handshake.
//
// Single-cycle ops (add/sub/inc/dec/logic, zero-amount shifts, opcodes 12-15)
// are computed straight from the inputs when start is accepted in IDLE.
// Shifts by a non-zero amount and the shift-add multiply run one bit per
// cycle in EJEC. Every op finishes with one cycle in FIN, which raises listo.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   A, B       operands (B[S-1:0] is the shift amount for shifts)
//   flagin     operand select for inc/dec/not: 1 = A, 0 = B
//   select     opcode
//   busy       high whenever the FSM is not in IDLE
//   listo      one-cycle completion pulse (the FIN state)
//   resultado  registered result
//   opnegativo, ozero, ocout, ooverflow  registered flags
module alu_secuencial #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flagin,
  input  logic [3:0]   select,
  output logic         busy,
  output logic         listo,
  output logic [N-1:0] resultado,
  output logic         opnegativo,
  output logic         ozero,
  output logic         ocout,
  output logic         ooverflow
);

  localparam int unsigned S = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EJEC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [S:0] CNT_ONE = (S+1)'(1);
  localparam logic [S:0] CNT_MUL = (S+1)'(N);

  logic [1:0]     state;
  logic [3:0]     sel_r;
  logic [S:0]     cnt;
  logic [N-1:0]   w;    // shift operand, or remaining multiplier bits
  logic [2*N-1:0] mc;   // multiplicand, shifted left once per step
  logic [2*N-1:0] acc;  // product accumulator

  logic           is_mul, is_shift, single;
  logic [N-1:0]   x;
  logic [N:0]     sum;
  logic [N-1:0]   res_c;
  logic           co_c, ov_c;

  logic [N-1:0]   w_nx;
  logic           bit_out;
  logic [2*N-1:0] acc_nx;

  logic           wr_en;
  logic [N-1:0]   wr_res;
  logic           wr_co, wr_ov;

  assign busy  = (state != IDLE);
  assign listo = (state == FIN);

  assign is_mul   = (select == 4'd11);
  assign is_shift = (select == 4'd8) || (select == 4'd9) || (select == 4'd10);
  assign single   = !is_mul && !(is_shift && (B[S-1:0] != '0));

  // Single-cycle datapath, evaluated on the live inputs at acceptance.
  always_comb begin
    x     = flagin ? A : B;
    sum   = '0;
    res_c = '0;
    co_c  = 1'b0;
    ov_c  = 1'b0;
    case (select)
      4'd0: begin
        sum   = {1'b0, A} + {1'b0, B};
        res_c = sum[N-1:0];
        co_c  = sum[N];
        ov_c  = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      4'd1: begin
        sum   = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
        res_c = sum[N-1:0];
        co_c  = sum[N];
        ov_c  = (A[N-1] != B[N-1]) && (sum[N-1] != A[N-1]);
      end
      4'd2: begin
        sum   = {1'b0, x} + {{N{1'b0}}, 1'b1};
        res_c = sum[N-1:0];
        co_c  = sum[N];
        ov_c  = !x[N-1] && sum[N-1];
      end
      4'd3: begin
        sum   = {1'b0, x} + {1'b0, {N{1'b1}}};
        res_c = sum[N-1:0];
        co_c  = sum[N];
        ov_c  = x[N-1] && !sum[N-1];
      end
      4'd4:                res_c = A & B;
      4'd5:                res_c = A | B;
      4'd6:                res_c = ~x;
      4'd7:                res_c = A ^ B;
      4'd8, 4'd9, 4'd10:   res_c = A;  // only reached with a zero shift amount
      default:             res_c = '0;
    endcase
  end

  // One EJEC step: a 1-bit shift, or one shift-add multiply iteration.
  always_comb begin
    w_nx    = w;
    bit_out = 1'b0;
    acc_nx  = acc + (w[0] ? mc : '0);
    case (sel_r)
      4'd8:    {bit_out, w_nx} = {w, 1'b0};
      4'd9:    {w_nx, bit_out} = {1'b0, w};
      4'd10:   {w_nx, bit_out} = {w[N-1], w};
      default: w_nx = w >> 1;
    endcase
  end

  // Output write: at acceptance for single-cycle ops, on the last EJEC step otherwise.
  assign wr_en = ((state == IDLE) && start && single) ||
                 ((state == EJEC) && (cnt == CNT_ONE));

  always_comb begin
    if (state == EJEC) begin
      if (sel_r == 4'd11) begin
        wr_res = acc_nx[N-1:0];
        wr_co  = |acc_nx[2*N-1:N];
        wr_ov  = |acc_nx[2*N-1:N];
      end else begin
        wr_res = w_nx;
        wr_co  = bit_out;
        wr_ov  = 1'b0;
      end
    end else begin
      wr_res = res_c;
      wr_co  = co_c;
      wr_ov  = ov_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_r      <= '0;
      cnt        <= '0;
      w          <= '0;
      mc         <= '0;
      acc        <= '0;
      resultado  <= '0;
      opnegativo <= 1'b0;
      ozero      <= 1'b0;
      ocout      <= 1'b0;
      ooverflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        resultado  <= wr_res;
        opnegativo <= wr_res[N-1];
        ozero      <= (wr_res == '0);
        ocout      <= wr_co;
        ooverflow  <= wr_ov;
      end
      case (state)
        IDLE: begin
          if (start) begin
            sel_r <= select;
            if (single) begin
              state <= FIN;
            end else begin
              state <= EJEC;
              if (is_mul) begin
                cnt <= CNT_MUL;
                w   <= B;
                mc  <= {{N{1'b0}}, A};
                acc <= '0;
              end else begin
                cnt <= {1'b0, B[S-1:0]};
                w   <= A;
              end
            end
          end
        end
        EJEC: begin
          w   <= w_nx;
          mc  <= mc << 1;
          acc <= acc_nx;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial (N=8). Each task drives one scenario and
// checks results against hand-computed values.
module tb_alu_secuencial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       flagin;
  logic [3:0] select;
  logic       busy, listo;
  logic [7:0] resultado;
  logic       opnegativo, ozero, ocout, ooverflow;
  logic [3:0] flags;

  int n_cmp = 0;
  int n_err = 0;

  // expected flags are written {neg, zero, cout, ovf}
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       fl;
    logic [3:0] sel;
    logic [7:0] r;
    logic [3:0] f;
    logic [3:0] lat;
  } vec_t;

  assign flags = {opnegativo, ozero, ocout, ooverflow};

  alu_secuencial #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .flagin     (flagin),
    .select     (select),
    .busy       (busy),
    .listo      (listo),
    .resultado  (resultado),
    .opnegativo (opnegativo),
    .ozero      (ozero),
    .ocout      (ocout),
    .ooverflow  (ooverflow)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE; lat = number of edges from the accepting
  // edge (1) to the edge that raises listo, capped at 40.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic fl,
                       input logic [3:0] sel, output int lat);
    @(negedge clk);
    A = a; B = b; flagin = fl; select = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; flagin = ~fl; select = 4'd12;
    lat = 1;
    while (listo !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; flagin = 1'b0; select = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (listo !== 1'b0) begin n_err++; $display("FAIL reset_listo got=%b exp=0", listo); end
    n_cmp++; if (resultado !== 8'h00) begin n_err++; $display("FAIL reset_res got=%h exp=00", resultado); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL reset_release got=%b exp=00", {busy, listo}); end
  endtask

  task automatic test_arith;
    vec_t v [9];
    int   lat;
    v = '{
      '{8'h7F, 8'h01, 1'b0, 4'd0, 8'h80, 4'b1001, 4'd1},
      '{8'h05, 8'h05, 1'b0, 4'd1, 8'h00, 4'b0110, 4'd1},
      '{8'h00, 8'hFF, 1'b0, 4'd2, 8'h00, 4'b0110, 4'd1},
      '{8'h05, 8'h07, 1'b0, 4'd1, 8'hFE, 4'b1000, 4'd1},
      '{8'h80, 8'h33, 1'b1, 4'd3, 8'h7F, 4'b0011, 4'd1},
      '{8'h44, 8'h00, 1'b0, 4'd3, 8'hFF, 4'b1000, 4'd1},
      '{8'h7F, 8'h00, 1'b1, 4'd2, 8'h80, 4'b1001, 4'd1},
      '{8'hFF, 8'hFF, 1'b0, 4'd0, 8'hFE, 4'b1010, 4'd1},
      '{8'h80, 8'h80, 1'b0, 4'd0, 8'h00, 4'b0111, 4'd1}
    };
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].a, v[i].b, v[i].fl, v[i].sel, lat);
      n_cmp++; if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL arith[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_cmp++; if (resultado !== v[i].r) begin n_err++; $display("FAIL arith[%0d]_res got=%h exp=%h", i, resultado, v[i].r); end
      n_cmp++; if (flags !== v[i].f) begin n_err++; $display("FAIL arith[%0d]_flags got=%b exp=%b", i, flags, v[i].f); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arith[%0d]_busy_in_fin got=%b exp=1", i, busy); end
      @(posedge clk); #1;
      n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL arith[%0d]_idle got=%b exp=00", i, {busy, listo}); end
    end
  endtask

  task automatic test_logic;
    vec_t v [7];
    int   lat;
    v = '{
      '{8'hF0, 8'h3C, 1'b0, 4'd4,  8'h30, 4'b0000, 4'd1},
      '{8'hF0, 8'h0C, 1'b0, 4'd5,  8'hFC, 4'b1000, 4'd1},
      '{8'hAA, 8'hAA, 1'b0, 4'd7,  8'h00, 4'b0100, 4'd1},
      '{8'h0F, 8'h00, 1'b1, 4'd6,  8'hF0, 4'b1000, 4'd1},
      '{8'h00, 8'hFF, 1'b0, 4'd6,  8'h00, 4'b0100, 4'd1},
      '{8'hFF, 8'hFF, 1'b0, 4'd13, 8'h00, 4'b0100, 4'd1},
      '{8'h01, 8'h02, 1'b1, 4'd15, 8'h00, 4'b0100, 4'd1}
    };
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].a, v[i].b, v[i].fl, v[i].sel, lat);
      n_cmp++; if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL logic[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_cmp++; if (resultado !== v[i].r) begin n_err++; $display("FAIL logic[%0d]_res got=%h exp=%h", i, resultado, v[i].r); end
      n_cmp++; if (flags !== v[i].f) begin n_err++; $display("FAIL logic[%0d]_flags got=%b exp=%b", i, flags, v[i].f); end
      @(posedge clk); #1;
      n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL logic[%0d]_idle got=%b exp=00", i, {busy, listo}); end
    end
  endtask

  task automatic test_shift;
    vec_t v [7];
    int   lat;
    v = '{
      '{8'h90, 8'h03, 1'b0, 4'd10, 8'hF2, 4'b1000, 4'd4},
      '{8'h81, 8'h01, 1'b0, 4'd8,  8'h02, 4'b0010, 4'd2},
      '{8'h81, 8'h02, 1'b0, 4'd9,  8'h20, 4'b0000, 4'd3},
      '{8'h81, 8'h08, 1'b0, 4'd9,  8'h81, 4'b1000, 4'd1},
      '{8'h01, 8'h07, 1'b0, 4'd8,  8'h80, 4'b1000, 4'd8},
      '{8'h01, 8'h01, 1'b0, 4'd10, 8'h00, 4'b0110, 4'd2},
      '{8'hFF, 8'h04, 1'b0, 4'd8,  8'hF0, 4'b1010, 4'd5}
    };
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].a, v[i].b, v[i].fl, v[i].sel, lat);
      n_cmp++; if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL shift[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_cmp++; if (resultado !== v[i].r) begin n_err++; $display("FAIL shift[%0d]_res got=%h exp=%h", i, resultado, v[i].r); end
      n_cmp++; if (flags !== v[i].f) begin n_err++; $display("FAIL shift[%0d]_flags got=%b exp=%b", i, flags, v[i].f); end
      @(posedge clk); #1;
      n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL shift[%0d]_idle got=%b exp=00", i, {busy, listo}); end
    end
  endtask

  task automatic test_multiply;
    vec_t v [5];
    int   lat;
    v = '{
      '{8'h0C, 8'h0B, 1'b0, 4'd11, 8'h84, 4'b1000, 4'd9},
      '{8'h10, 8'h10, 1'b0, 4'd11, 8'h00, 4'b0111, 4'd9},
      '{8'hFF, 8'hFF, 1'b0, 4'd11, 8'h01, 4'b0011, 4'd9},
      '{8'h07, 8'h09, 1'b0, 4'd11, 8'h3F, 4'b0000, 4'd9},
      '{8'h00, 8'hFF, 1'b0, 4'd11, 8'h00, 4'b0100, 4'd9}
    };
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].a, v[i].b, v[i].fl, v[i].sel, lat);
      n_cmp++; if (lat !== int'(v[i].lat)) begin n_err++; $display("FAIL mul[%0d]_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      n_cmp++; if (resultado !== v[i].r) begin n_err++; $display("FAIL mul[%0d]_res got=%h exp=%h", i, resultado, v[i].r); end
      n_cmp++; if (flags !== v[i].f) begin n_err++; $display("FAIL mul[%0d]_flags got=%b exp=%b", i, flags, v[i].f); end
      @(posedge clk); #1;
      n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL mul[%0d]_idle got=%b exp=00", i, {busy, listo}); end
    end
  endtask

  // A second start with different operands arrives mid-multiply.
  task automatic test_start_ignored;
    int pulses = 0;
    int first  = 0;
    logic [7:0] r_at = 8'h00;
    logic [3:0] f_at = 4'h0;
    @(negedge clk);
    A = 8'h0C; B = 8'h0B; flagin = 1'b0; select = 4'd11; start = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (listo === 1'b1) begin
        pulses++;
        if (first == 0) begin first = e; r_at = resultado; f_at = flags; end
      end
      if (e == 1) start = 1'b0;
      if (e == 3) begin A = 8'h10; B = 8'h10; select = 4'd0; start = 1'b1; end
      if (e == 4) start = 1'b0;
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (first !== 9) begin n_err++; $display("FAIL ignore_listo_edge got=%0d exp=9", first); end
    n_cmp++; if (r_at !== 8'h84) begin n_err++; $display("FAIL ignore_res got=%h exp=84", r_at); end
    n_cmp++; if (f_at !== 4'b1000) begin n_err++; $display("FAIL ignore_flags got=%b exp=1000", f_at); end
    n_cmp++; if (resultado !== 8'h84) begin n_err++; $display("FAIL ignore_res_held got=%h exp=84", resultado); end
  endtask

  // rst_n pulled low for one cycle partway through a multiply.
  task automatic test_reset_mid_mul;
    int pulses = 0;
    int lat;
    @(negedge clk);
    A = 8'h0C; B = 8'h0B; flagin = 1'b0; select = 4'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL midrst_busy_listo got=%b exp=00", {busy, listo}); end
    n_cmp++; if (resultado !== 8'h00) begin n_err++; $display("FAIL midrst_res got=%h exp=00", resultado); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL midrst_flags got=%b exp=0000", flags); end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (listo === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_listo got=%0d exp=0", pulses); end
    n_cmp++; if (resultado !== 8'h00) begin n_err++; $display("FAIL midrst_res_after got=%h exp=00", resultado); end
    do_op(8'h03, 8'h04, 1'b0, 4'd0, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL midrst_add_latency got=%0d exp=1", lat); end
    n_cmp++; if (resultado !== 8'h07) begin n_err++; $display("FAIL midrst_add_res got=%h exp=07", resultado); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL midrst_add_flags got=%b exp=0000", flags); end
    @(posedge clk); #1;
  endtask

  // start held from FIN: ignored in FIN, accepted on the following IDLE cycle.
  task automatic test_back_to_back;
    int lat;
    do_op(8'h01, 8'h02, 1'b0, 4'd0, lat);
    n_cmp++; if (resultado !== 8'h03) begin n_err++; $display("FAIL b2b_first_res got=%h exp=03", resultado); end
    A = 8'h10; B = 8'h20; flagin = 1'b0; select = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL b2b_gap got=%b exp=00", {busy, listo}); end
    n_cmp++; if (resultado !== 8'h03) begin n_err++; $display("FAIL b2b_held got=%h exp=03", resultado); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL b2b_second_listo got=%b exp=1", listo); end
    n_cmp++; if (resultado !== 8'h30) begin n_err++; $display("FAIL b2b_second_res got=%h exp=30", resultado); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, listo} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got=%b exp=00", {busy, listo}); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_shift;
    test_multiply;
    test_start_ignored;
    test_reset_mid_mul;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
